// File: rtl/ibex_if_id_pkg.sv
// Shared types for the IF/ID hand-off pipe: occupancy state, entry payload, PC step helper.
package ibex_if_id_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } if_id_state_e;

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] addr;
    logic            err;
    logic            err_plus2;
    logic            is_compressed;
  } if_id_entry_t;

  function automatic logic [XLEN-1:0] pc_step(input logic is_compressed);
    return is_compressed ? XLEN'(2) : XLEN'(4);
  endfunction

endpackage

// File: rtl/ibex_if_id_pipe_if.sv
// Fetch-side, ID-side and context-switch signals of the IF/ID pipe.
interface ibex_if_id_pipe_if;
  import ibex_if_id_pkg::*;

  logic            fetch_valid_i;
  logic            fetch_ready_o;
  logic [XLEN-1:0] fetch_rdata_i;
  logic [XLEN-1:0] fetch_addr_i;
  logic            fetch_err_i;
  logic            fetch_err_plus2_i;
  logic            flush_i;
  logic            id_ready_i;
  logic            instr_valid_id_o;
  logic [XLEN-1:0] instr_rdata_id_o;
  logic [XLEN-1:0] instr_addr_id_o;
  logic            instr_is_compressed_o;
  logic            instr_err_o;
  logic            instr_err_plus2_o;
  logic [XLEN-1:0] next_pc_o;
  logic            backup_i;
  logic            restore_i;
  logic            pc_mismatch_o;

  modport master (
    output fetch_valid_i, fetch_rdata_i, fetch_addr_i, fetch_err_i, fetch_err_plus2_i,
    output flush_i, id_ready_i, backup_i, restore_i,
    input  fetch_ready_o, instr_valid_id_o, instr_rdata_id_o, instr_addr_id_o,
    input  instr_is_compressed_o, instr_err_o, instr_err_plus2_o, next_pc_o, pc_mismatch_o
  );

  modport slave (
    input  fetch_valid_i, fetch_rdata_i, fetch_addr_i, fetch_err_i, fetch_err_plus2_i,
    input  flush_i, id_ready_i, backup_i, restore_i,
    output fetch_ready_o, instr_valid_id_o, instr_rdata_id_o, instr_addr_id_o,
    output instr_is_compressed_o, instr_err_o, instr_err_plus2_o, next_pc_o, pc_mismatch_o
  );

endinterface

// File: rtl/ibex_if_id_shadow.sv
// Single-slot snapshot of the pipe state (occupancy plus both entries) for context switching.
module ibex_if_id_shadow
  import ibex_if_id_pkg::*;
#(
  parameter bit ResetAll = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         backup,
  input  logic         restore,
  input  if_id_state_e cur_state,
  input  if_id_entry_t cur_h,
  input  if_id_entry_t cur_s,
  output if_id_state_e sh_state,
  output if_id_entry_t sh_h,
  output if_id_entry_t sh_s
);

  // A restore in the same cycle keeps the stored snapshot intact.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_state <= EMPTY;
      if (ResetAll) begin
        sh_h <= '0;
        sh_s <= '0;
      end
    end else if (backup && !restore) begin
      sh_state <= cur_state;
      sh_h     <= cur_h;
      sh_s     <= cur_s;
    end
  end

endmodule

// File: rtl/ibex_if_id_pipe.sv
// Two-entry skid-buffered IF/ID hand-off register with flush and backup/restore.
// Optional sequential-PC checker enabled by defining IF_ID_PIPE_PC_CHECK_EN.
module ibex_if_id_pipe
  import ibex_if_id_pkg::*;
#(
  parameter bit ResetAll = 1'b0,
  parameter bit BackupEn = 1'b1
) (
  input logic              clk_i,
  input logic              rst_i,
  ibex_if_id_pipe_if.slave bus
);

  if_id_state_e state;
  if_id_entry_t h, s, cap;
  if_id_state_e sh_state;
  if_id_entry_t sh_h, sh_s;
  logic         restore_en;
  logic         accept, pop;

  always_comb begin
    cap               = '0;
    cap.rdata         = bus.fetch_rdata_i;
    cap.addr          = bus.fetch_addr_i;
    cap.err           = bus.fetch_err_i;
    cap.err_plus2     = bus.fetch_err_plus2_i;
    cap.is_compressed = (bus.fetch_rdata_i[1:0] != 2'b11);
  end

  assign bus.fetch_ready_o         = (state != TWO);
  assign bus.instr_valid_id_o      = (state != EMPTY) && !bus.flush_i;
  assign bus.instr_rdata_id_o      = h.rdata;
  assign bus.instr_addr_id_o       = h.addr;
  assign bus.instr_is_compressed_o = h.is_compressed;
  assign bus.instr_err_o           = h.err;
  assign bus.instr_err_plus2_o     = h.err_plus2 && !h.is_compressed;
  assign bus.next_pc_o             = h.addr + pc_step(h.is_compressed);

  assign accept = bus.fetch_valid_i && bus.fetch_ready_o;
  assign pop    = bus.instr_valid_id_o && bus.id_ready_i;

  if (BackupEn) begin : g_shadow
    ibex_if_id_shadow #(.ResetAll(ResetAll)) u_shadow (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .backup    (bus.backup_i),
      .restore   (bus.restore_i),
      .cur_state (state),
      .cur_h     (h),
      .cur_s     (s),
      .sh_state  (sh_state),
      .sh_h      (sh_h),
      .sh_s      (sh_s)
    );
    assign restore_en = bus.restore_i;
  end else begin : g_no_shadow
    assign sh_state   = EMPTY;
    assign sh_h       = '0;
    assign sh_s       = '0;
    assign restore_en = 1'b0;
  end

  // Occupancy FSM and entry storage; flush beats restore beats normal traffic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= EMPTY;
      if (ResetAll) begin
        h <= '0;
        s <= '0;
      end
    end else if (bus.flush_i) begin
      state <= EMPTY;
    end else if (restore_en) begin
      state <= sh_state;
      h     <= sh_h;
      s     <= sh_s;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            h     <= cap;
            state <= ONE;
          end
        end
        ONE: begin
          if (pop && accept) begin
            h <= cap;
          end else if (pop) begin
            state <= EMPTY;
          end else if (accept) begin
            s     <= cap;
            state <= TWO;
          end
        end
        TWO: begin
          if (pop) begin
            h     <= s;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef IF_ID_PIPE_PC_CHECK_EN
  logic            exp_valid;
  logic [XLEN-1:0] exp_pc;
  logic            mismatch;

  // Expected fetch address follows the last accepted entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exp_valid <= 1'b0;
      exp_pc    <= '0;
      mismatch  <= 1'b0;
    end else if (bus.flush_i || restore_en) begin
      exp_valid <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      mismatch <= accept && exp_valid && (bus.fetch_addr_i != exp_pc);
      if (accept) begin
        exp_pc    <= bus.fetch_addr_i + pc_step(cap.is_compressed);
        exp_valid <= 1'b1;
      end
    end
  end

  assign bus.pc_mismatch_o = mismatch;
`else
  assign bus.pc_mismatch_o = 1'b0;
`endif

endmodule
